fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
// - Parametrised PC/fetch sequencer for the RV32I core; replaces the bare PC register, PC+4 adder and next-PC muxes.
// - Boot phase: streams a program into instruction memory over a valid/ready handshake. Run phase: drives fetch PC.
// - Next-PC priority is jalr > jal/branch > PC+4. Supports stall, misaligned/out-of-range target trap and a retired-instruction counter.
// - Sits between the control unit/ALU outputs and i_mem; `run` gates the core's architectural writes.
// PARAMETERS
// - XLEN          32     datapath/address width
// - IMEM_DEPTH    256    instruction memory depth in words; power of 2, >= 2
// - RESET_VECTOR  0      PC loaded on entering RUN; word aligned, < IMEM_DEPTH*4
// - BOOT_ENABLE   1      1: reset enters BOOT; 0: reset enters RUN directly
// - localparam AW = $clog2(IMEM_DEPTH)
// PORTS
// - clk          in   1     rising-edge clock
// - rst          in   1     asynchronous, active-low reset
// - boot_valid   in   1     loader word valid
// - boot_ready   out  1     loader word accepted when valid&ready
// - boot_data    in   XLEN  instruction word to load
// - boot_last    in   1     final word of program
// - imem_wr_en   out  1     i_mem write strobe
// - imem_wr_data out  XLEN  i_mem write data (= boot_data)
// - imem_wr_addr out  XLEN  i_mem byte write address (word index << 2)
// - pc           out  XLEN  current fetch address to i_mem
// - pc_plus4     out  XLEN  pc + 4, for write-back of jal/jalr
// - stall        in   1     hold PC this cycle
// - jal          in   1     from ctrl
// - jalr         in   1     from ctrl
// - bcond        in   1     branch taken, from ALU
// - br_target    in   XLEN  pc + imm, from branch adder
// - jalr_target  in   XLEN  rs1 + imm, from ALU
// - run          out  1     core enabled (state == RUN)
// - trap         out  1     sticky fault flag
// - trap_addr    out  XLEN  offending target address
// - boot_ovf     out  1     sticky: memory filled before boot_last
// - retired      out  32    instructions retired in RUN (wraps at 2^32)
// BEHAVIOUR
// - States: BOOT, RUN, HALT. Reset → BOOT if BOOT_ENABLE else RUN.
// - Reset values: pc = RESET_VECTOR; word counter, retired, trap, trap_addr, boot_ovf = 0; run = !BOOT_ENABLE.
// - BOOT:
//   - boot_ready = 1.
//   - imem_wr_en = boot_valid & boot_ready; combinational, same-cycle write.
//   - imem_wr_addr = cnt<<2; cnt increments on each accepted word.
//   - Accepted word with boot_last=1 → RUN next cycle, pc = RESET_VECTOR.
//   - Accepted word at cnt == IMEM_DEPTH-1 with boot_last=0 → RUN, boot_ovf = 1.
//   - Word with valid & last at cnt == DEPTH-1 → RUN, boot_ovf stays 0.
//   - In BOOT, jal/jalr/bcond/stall are ignored and pc holds RESET_VECTOR.
// - RUN: boot_ready = 0, imem_wr_en = 0. Each non-stalled cycle:
//   - tgt = jalr ? (jalr_target & ~1) : (jal|bcond) ? br_target : pc+4.
//   - If tgt[1:0] != 0 or tgt >= IMEM_DEPTH*4 → HALT: trap = 1, trap_addr = tgt, pc holds.
//   - Otherwise pc <= tgt and retired++.
//   - Stall=1: pc and retired hold; stall wins over any redirect.
//   - pc+4 stepping past the end of memory also traps; it never wraps.
// - HALT: run = 0; pc, retired, trap_addr frozen; leave only via reset.
// - pc_plus4 is combinational; all adds are modulo 2^XLEN.
// - Async reset mid-boot or mid-run: immediate return to reset values. Loaded i_mem contents are not cleared.
// STRUCTURE
// - fetch_pkg: state enum {BOOT, RUN, HALT}, next-PC select codes {SEQ, BR, JALR}, XLEN default.
// - One sub-module: imem_boot_loader (handshake, word counter, overflow detection, i_mem write port). Outputs a done pulse to the FSM.
// - Top holds the FSM, next-PC mux, range/alignment check and retired counter.
// TESTING
// - Boot 4 words (last on 4th), DEPTH=256: writes at 0x0,0x4,0x8,0xC; RUN next cycle; pc=0; boot_ovf=0.
// - DEPTH=4, 5 valid words, no last: 4 writes, 4th accepted → RUN, boot_ovf=1; 5th word not written (boot_ready=0).
// - RUN from 0, no redirects, stall on cycle 3: pc sequence 0,4,8,8,C; retired=3 after 4 cycles.
// - pc=0x10, jal=1, bcond=1, jalr=1, jalr_target=0x21, br_target=0x40: next pc=0x20 (jalr wins, bit0 cleared).
// - br_target=0x42 with bcond=1: trap=1, trap_addr=0x42, run=0, pc stays 0x10, retired frozen.
// - DEPTH=256 with br_target=0x400: trap. Assert rst mid-boot after 2 words: boot_ready, cnt, pc return to reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, next-PC select codes and
// the select-priority helper.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JALR = 2'd2
    } npc_sel_t;

    // jalr outranks jal/branch, which outrank sequential fetch
    function automatic npc_sel_t npc_select(input logic jal, input logic jalr, input logic bcond);
        npc_sel_t sel;
        sel = SEL_SEQ;
        if (jalr) begin
            sel = SEL_JALR;
        end else if (jal || bcond) begin
            sel = SEL_BR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Boot-time program loader: accepts words over valid/ready, writes them to
// consecutive i_mem words and reports completion or overflow.
module imem_boot_loader
    import fetch_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int IMEM_DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            active,
    input  logic            boot_valid,
    input  logic [XLEN-1:0] boot_data,
    input  logic            boot_last,
    output logic            boot_ready,
    output logic            imem_wr_en,
    output logic [XLEN-1:0] imem_wr_data,
    output logic [XLEN-1:0] imem_wr_addr,
    output logic            done,
    output logic            boot_ovf
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [AW-1:0] CNT_MAX = AW'(IMEM_DEPTH - 1);

    logic [AW-1:0] cnt;
    logic          accept;
    logic          at_end;

    assign boot_ready   = active;
    assign accept       = boot_valid && boot_ready;
    assign at_end       = (cnt == CNT_MAX);
    assign imem_wr_en   = accept;
    assign imem_wr_data = boot_data;
    assign imem_wr_addr = XLEN'({cnt, 2'b00});
    // a last word landing in the final slot is a clean finish, not an overflow
    assign done         = accept && (boot_last || at_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            boot_ovf <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + AW'(1);
            if (at_end && !boot_last) begin
                boot_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC/fetch sequencer: boot-time i_mem loader, then next-PC selection with
// stall, alignment/range trap and a retired-instruction counter.
//
// state | meaning
// BOOT  | streaming program into i_mem, pc parked at RESET_VECTOR
// RUN   | fetching; pc advances each non-stalled cycle
// HALT  | trapped on a bad target; everything frozen until reset
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter int              IMEM_DEPTH   = 256,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              BOOT_ENABLE  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            boot_valid,
    output logic            boot_ready,
    input  logic [XLEN-1:0] boot_data,
    input  logic            boot_last,
    output logic            imem_wr_en,
    output logic [XLEN-1:0] imem_wr_data,
    output logic [XLEN-1:0] imem_wr_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            stall,
    input  logic            jal,
    input  logic            jalr,
    input  logic            bcond,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            run,
    output logic            trap,
    output logic [XLEN-1:0] trap_addr,
    output logic            boot_ovf,
    output logic [31:0]     retired
);

    localparam state_t          RESET_STATE = BOOT_ENABLE ? ST_BOOT : ST_RUN;
    localparam logic [XLEN:0]   MEM_BYTES   = (XLEN + 1)'(IMEM_DEPTH) << 2;
    localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);

    state_t          state;
    state_t          state_nxt;
    npc_sel_t        sel;
    logic [XLEN-1:0] tgt;
    logic            tgt_bad;
    logic            boot_done;
    logic [XLEN-1:0] pc_nxt;
    logic [31:0]     retired_nxt;
    logic            trap_nxt;
    logic [XLEN-1:0] trap_addr_nxt;

    imem_boot_loader #(
        .XLEN       (XLEN),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_loader (
        .clk          (clk),
        .rst          (rst),
        .active       (state == ST_BOOT),
        .boot_valid   (boot_valid),
        .boot_data    (boot_data),
        .boot_last    (boot_last),
        .boot_ready   (boot_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_data (imem_wr_data),
        .imem_wr_addr (imem_wr_addr),
        .done         (boot_done),
        .boot_ovf     (boot_ovf)
    );

    assign pc_plus4 = pc + PC_STEP;
    assign run      = (state == ST_RUN);

    always_comb begin
        sel = npc_select(jal, jalr, bcond);
        case (sel)
            SEL_JALR: tgt = {jalr_target[XLEN-1:1], 1'b0};
            SEL_BR:   tgt = br_target;
            default:  tgt = pc_plus4;
        endcase
        // sequential overrun past the last word traps as well; pc never wraps
        tgt_bad = (tgt[1:0] != 2'b00) || ({1'b0, tgt} >= MEM_BYTES);
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        retired_nxt   = retired;
        trap_nxt      = trap;
        trap_addr_nxt = trap_addr;
        case (state)
            ST_BOOT: begin
                if (boot_done) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = RESET_VECTOR;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (tgt_bad) begin
                        state_nxt     = ST_HALT;
                        trap_nxt      = 1'b1;
                        trap_addr_nxt = tgt;
                    end else begin
                        pc_nxt      = tgt;
                        retired_nxt = retired + 32'd1;
                    end
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RESET_STATE;
            pc        <= RESET_VECTOR;
            retired   <= '0;
            trap      <= 1'b0;
            trap_addr <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            retired   <= retired_nxt;
            trap      <= trap_nxt;
            trap_addr <= trap_addr_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a 256-word instance for boot/run/redirect/trap
// and a 4-word instance for overflow and end-of-memory behaviour.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] boot_data;

    logic        boot_valid, boot_last, stall, jal, jalr, bcond;
    logic [31:0] br_target, jalr_target;
    logic        boot_ready, imem_wr_en, run, trap, boot_ovf;
    logic [31:0] imem_wr_data, imem_wr_addr, pc, pc_plus4, trap_addr, retired;

    logic        s_valid, s_last, s_stall;
    logic        s_boot_ready, s_wr_en, s_run, s_trap, s_boot_ovf;
    logic [31:0] s_wr_data, s_wr_addr, s_pc, s_pc_plus4, s_trap_addr, s_retired;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.IMEM_DEPTH(256)) u_dut (
        .clk(clk), .rst(rst),
        .boot_valid(boot_valid), .boot_ready(boot_ready), .boot_data(boot_data), .boot_last(boot_last),
        .imem_wr_en(imem_wr_en), .imem_wr_data(imem_wr_data), .imem_wr_addr(imem_wr_addr),
        .pc(pc), .pc_plus4(pc_plus4), .stall(stall), .jal(jal), .jalr(jalr), .bcond(bcond),
        .br_target(br_target), .jalr_target(jalr_target), .run(run), .trap(trap),
        .trap_addr(trap_addr), .boot_ovf(boot_ovf), .retired(retired)
    );

    fetch_ctrl #(.IMEM_DEPTH(4)) u_small (
        .clk(clk), .rst(rst),
        .boot_valid(s_valid), .boot_ready(s_boot_ready), .boot_data(boot_data), .boot_last(s_last),
        .imem_wr_en(s_wr_en), .imem_wr_data(s_wr_data), .imem_wr_addr(s_wr_addr),
        .pc(s_pc), .pc_plus4(s_pc_plus4), .stall(s_stall), .jal(1'b0), .jalr(1'b0), .bcond(1'b0),
        .br_target(32'h0), .jalr_target(32'h0), .run(s_run), .trap(s_trap),
        .trap_addr(s_trap_addr), .boot_ovf(s_boot_ovf), .retired(s_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; boot_data = '0;
        boot_valid = 0; boot_last = 0; stall = 0; jal = 0; jalr = 0; bcond = 0;
        br_target = '0; jalr_target = '0;
        s_valid = 0; s_last = 0; s_stall = 1;
        #2;
        chk("rst_run", run, 0);
        chk("rst_ready", boot_ready, 1);
        chk("rst_pc", pc, 0);
        chk("rst_retired", retired, 0);
        chk("rst_trap", trap, 0);
        chk("rst_trap_addr", trap_addr, 0);
        chk("rst_ovf", boot_ovf, 0);
        chk("rst_wr_addr", imem_wr_addr, 0);
        chk("rst_s_run", s_run, 0);
        #1 rst = 1'b1;
        tick();

        // small instance: 5 words, no last -> overflow after the 4th
        for (int i = 0; i < 5; i++) begin
            s_valid = 1; boot_data = 32'hC0 + i;
            #1;
            if (i < 4) begin
                chk("s_wr_en", s_wr_en, 1);
                chk("s_wr_addr", s_wr_addr, 32'(i * 4));
                chk("s_wr_data", s_wr_data, 32'hC0 + i);
            end else begin
                chk("s_5th_wr_en", s_wr_en, 0);
                chk("s_5th_ready", s_boot_ready, 0);
                chk("s_run", s_run, 1);
                chk("s_ovf", s_boot_ovf, 1);
            end
            tick();
        end
        s_valid = 0;
        chk("s_pc_stalled", s_pc, 0);
        chk("big_still_boot", run, 0);

        // big instance: 4 words, last on the 4th
        for (int i = 0; i < 4; i++) begin
            boot_valid = 1; boot_last = (i == 3); boot_data = 32'hA0 + i;
            #1;
            chk("wr_en", imem_wr_en, 1);
            chk("wr_addr", imem_wr_addr, 32'(i * 4));
            chk("wr_data", imem_wr_data, 32'hA0 + i);
            tick();
        end
        boot_valid = 0; boot_last = 0;
        chk("boot_run", run, 1);
        chk("boot_pc", pc, 0);
        chk("boot_ovf", boot_ovf, 0);
        chk("boot_ready_run", boot_ready, 0);

        tick(); chk("seq_pc1", pc, 32'h4);
        tick(); chk("seq_pc2", pc, 32'h8);
        stall = 1;
        tick(); chk("stall_pc", pc, 32'h8); chk("stall_ret", retired, 2);
        stall = 0;
        tick(); chk("seq_pc4", pc, 32'hC); chk("seq_ret", retired, 3);
        chk("pc_plus4", pc_plus4, 32'h10);
        tick(); chk("seq_pc5", pc, 32'h10);

        stall = 1; jalr = 1; jalr_target = 32'h21;
        tick(); chk("stall_wins_pc", pc, 32'h10); chk("stall_wins_ret", retired, 4);
        stall = 0; jalr = 0; bcond = 1; br_target = 32'h42;
        tick();
        chk("mis_trap", trap, 1);
        chk("mis_trap_addr", trap_addr, 32'h42);
        chk("mis_run", run, 0);
        chk("mis_pc", pc, 32'h10);
        chk("mis_ret", retired, 4);
        bcond = 0;
        tick(); chk("halt_pc", pc, 32'h10); chk("halt_ret", retired, 4); chk("halt_run", run, 0);

        // small instance: sequential stepping off the end of 4-word memory
        s_stall = 0;
        tick(); chk("s_pc1", s_pc, 32'h4);
        tick(); chk("s_pc2", s_pc, 32'h8);
        tick(); chk("s_pc3", s_pc, 32'hC); chk("s_pc_plus4", s_pc_plus4, 32'h10);
        tick();
        chk("s_end_trap", s_trap, 1);
        chk("s_end_trap_addr", s_trap_addr, 32'h10);
        chk("s_end_pc", s_pc, 32'hC);
        chk("s_end_ret", s_retired, 3);
        chk("s_end_run", s_run, 0);
        s_stall = 1;

        // fresh reset, then reset again mid-boot after 2 words
        #1 rst = 0;
        #1 rst = 1;
        for (int i = 0; i < 2; i++) begin
            boot_valid = 1; boot_data = 32'hB0 + i;
            tick();
        end
        chk("mid_cnt", imem_wr_addr, 32'h8);
        #2 rst = 0;
        #1;
        chk("mid_rst_ready", boot_ready, 1);
        chk("mid_rst_cnt", imem_wr_addr, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_run", run, 0);
        chk("mid_rst_trap", trap, 0);
        chk("mid_rst_ret", retired, 0);
        boot_valid = 0;
        rst = 1;
        tick();

        boot_valid = 1; boot_last = 1; boot_data = 32'hD0;
        tick();
        boot_valid = 0; boot_last = 0; stall = 1;
        chk("one_word_run", run, 1);

        // small instance: last word exactly in the final slot is not overflow
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_last = (i == 3); boot_data = 32'hE0 + i;
            tick();
        end
        s_valid = 0; s_last = 0;
        chk("s_last_run", s_run, 1);
        chk("s_last_ovf", s_boot_ovf, 0);

        stall = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("re_pc", pc, 32'h10);
        jal = 1; bcond = 1; jalr = 1; jalr_target = 32'h21; br_target = 32'h40;
        tick(); chk("jalr_pc", pc, 32'h20); chk("jalr_ret", retired, 5);
        jalr = 0; bcond = 0; br_target = 32'h3C;
        tick(); chk("jal_pc", pc, 32'h3C);
        jal = 0; bcond = 1; br_target = 32'h400;
        tick();
        chk("range_trap", trap, 1);
        chk("range_trap_addr", trap_addr, 32'h400);
        chk("range_pc", pc, 32'h3C);
        chk("range_run", run, 0);
        bcond = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
